// File: rtl/kc_aes_pkg.sv
// Shared AES state types and row-permutation helpers used by both cipher directions.
package kc_aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    localparam int NB_ROWS = 4;
    localparam int NB_COLS = 4;

    // Column-major layout: byte(r,c) occupies state[byte_idx(r,c) -: 8].
    function automatic int byte_idx(input int r, input int c);
        return 127 - 8 * (NB_ROWS * c + r);
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < NB_ROWS; r++) begin
            for (int c = 0; c < NB_COLS; c++) begin
                o[byte_idx(r, c) -: 8] = s[byte_idx(r, (c + r) % NB_COLS) -: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < NB_ROWS; r++) begin
            for (int c = 0; c < NB_COLS; c++) begin
                o[byte_idx(r, c) -: 8] = s[byte_idx(r, (c - r + NB_COLS) % NB_COLS) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_shift_rows_stage_if.sv
// Stream bundle of the InvShiftRows stage: input side, output side and status.
interface inv_shift_rows_stage_if;
    import kc_aes_pkg::*;

    state_t     state_i;
    logic       valid_i;
    logic       ready_o;
    state_t     state_o;
    logic       valid_o;
    logic       ready_i;
    logic       done_o;
    logic [3:0] level_o;
    logic       err_o;

    modport slave (
        input  state_i, valid_i, ready_i,
        output ready_o, state_o, valid_o, done_o, level_o, err_o
    );

    modport master (
        output state_i, valid_i, ready_i,
        input  ready_o, state_o, valid_o, done_o, level_o, err_o
    );

endinterface

// File: rtl/inv_shift_rows_perm.sv
// Purely combinational InvShiftRows byte permutation (row r rotated right by r).
module inv_shift_rows_perm
    import kc_aes_pkg::*;
(
    input  state_t state_i,
    output state_t state_o
);

    assign state_o = inv_shift_rows(state_i);

endmodule

// File: rtl/inv_shift_rows_stage.sv
// InvShiftRows valid/ready stage with a DEPTH-entry output FIFO.
// Optional feature macro: KC_ISR_SELFCHECK_EN (shadow raw-input buffer + forward-ShiftRows check).
module inv_shift_rows_stage
    import kc_aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    inv_shift_rows_stage_if.slave   s
);

    localparam int             PW    = $clog2(DEPTH);
    localparam logic [PW-1:0]  LAST  = PW'(DEPTH - 1);
    localparam logic [3:0]     FULL  = 4'(DEPTH);

    state_t         perm_w;
    state_t         buf_q [DEPTH];
    state_t         buf_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]     level_q, level_d;
    logic           done_q, done_d;
    logic           push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    inv_shift_rows_perm u_perm (
        .state_i (s.state_i),
        .state_o (perm_w)
    );

    // Handshakes qualify on registered level only, so ready_o/valid_o never see ready_i/valid_i.
    assign push = s.valid_i & (level_q != FULL);
    assign pop  = s.ready_i & (level_q != 4'd0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        done_d   = pop;
        if (push) begin
            buf_d[wr_ptr_q] = perm_w;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: buffer entries are reset too, so state_o reads 0 straight out of reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            done_q   <= done_d;
        end
    end

    assign s.ready_o = (level_q != FULL);
    assign s.valid_o = (level_q != 4'd0);
    assign s.state_o = buf_q[rd_ptr_q];
    assign s.done_o  = done_q;
    assign s.level_o = level_q;

`ifdef KC_ISR_SELFCHECK_EN
    state_t raw_q [DEPTH];
    state_t raw_d [DEPTH];
    logic   err_q, err_d;

    // Forward ShiftRows of the popped entry must reproduce the raw input it came from.
    always_comb begin
        raw_d = raw_q;
        if (push) begin
            raw_d[wr_ptr_q] = s.state_i;
        end
        err_d = err_q | (pop & (shift_rows(s.state_o) != raw_q[rd_ptr_q]));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                raw_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            raw_q <= raw_d;
            err_q <= err_d;
        end
    end

    assign s.err_o = err_q;
`else
    assign s.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Self-checking bench for inv_shift_rows_stage: byte-array reference model plus directed scenarios.
module tb_inv_shift_rows_stage;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    inv_shift_rows_stage_if bus ();

    inv_shift_rows_stage #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [127:0] exp_q [$];
    logic         mdl_done = 1'b0;

    int done_total = 0;
    int run_len    = 0;
    int max_run    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: view the state as a 4x4 byte grid and rotate row r by r columns.
    function automatic logic [127:0] model_rot(input logic [127:0] s, input bit inverse);
        logic [7:0]   g [4][4];
        logic [127:0] o;
        int           src;
        for (int k = 0; k < 16; k++) g[k % 4][k / 4] = s[127 - 8 * k -: 8];
        o = '0;
        for (int k = 0; k < 16; k++) begin
            src = inverse ? ((k / 4) + 4 - (k % 4)) % 4 : ((k / 4) + (k % 4)) % 4;
            o[127 - 8 * k -: 8] = g[k % 4][src];
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Compare process: outputs are checked on every falling edge, then the model advances
    // with the inputs that will be seen at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mdl_done = 1'b0;
        end else begin
            bit push, pop;
            check("level_o", 128'(bus.level_o), 128'(exp_q.size()));
            check("valid_o", 128'(bus.valid_o), 128'(exp_q.size() != 0));
            check("ready_o", 128'(bus.ready_o), 128'(exp_q.size() != DEPTH));
            check("done_o",  128'(bus.done_o),  128'(mdl_done));
            check("err_o",   128'(bus.err_o),   128'(0));
            if (exp_q.size() != 0) check("state_o", bus.state_o, exp_q[0]);
            push = bus.valid_i && (exp_q.size() < DEPTH);
            pop  = bus.ready_i && (exp_q.size() != 0);
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(model_rot(bus.state_i, 1'b1));
            mdl_done = pop;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            done_total++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] st);
        int n;
        n = 0;
        bus.valid_i = 1'b1;
        bus.state_i = st;
        forever begin
            @(negedge clk);
            if (bus.ready_o) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 128'(n), 128'(0));
                break;
            end
        end
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (bus.level_o != 4'd0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_bound", 128'(n < 100), 128'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t1, lit1, a, b, c, x, y, orig;
        int           d0;
        bit           stream_done;

        t1   = 128'h000102030405060708090a0b0c0d0e0f;
        lit1 = 128'h000d0a0704010e0b0805020f0c090603;

        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.state_i = '0;

        // Model pins against hand-derived values.
        check("model_inv_pin", model_rot(t1, 1'b1), lit1);
        check("model_fwd_pin", model_rot(lit1, 1'b0), t1);

        #3;
        check("rst_valid_o", 128'(bus.valid_o), 128'(0));
        check("rst_ready_o", 128'(bus.ready_o), 128'(1));
        check("rst_level_o", 128'(bus.level_o), 128'(0));
        check("rst_state_o", bus.state_o, 128'(0));
        #19 rst_n = 1'b1;

        // 1: single transfer, latency one cycle, done one cycle after pop.
        tick();
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.state_i = t1;
        tick();
        bus.valid_i = 1'b0;
        check("t1_valid", 128'(bus.valid_o), 128'(1));
        check("t1_state", bus.state_o, lit1);
        check("t1_done_early", 128'(bus.done_o), 128'(0));
        tick();
        check("t1_done", 128'(bus.done_o), 128'(1));
        check("t1_empty", 128'(bus.valid_o), 128'(0));
        tick();
        check("t1_done_pulse", 128'(bus.done_o), 128'(0));

        // 2: back-pressure, third state held until downstream drains.
        bus.ready_i = 1'b0;
        a = rand128(); b = rand128(); c = rand128();
        send(a);
        send(b);
        check("bp_level", 128'(bus.level_o), 128'(2));
        check("bp_ready", 128'(bus.ready_o), 128'(0));
        fork
            send(c);
            begin
                repeat (3) tick();
                check("bp_still_full", 128'(bus.level_o), 128'(2));
                check("bp_head_stable", bus.state_o, model_rot(a, 1'b1));
                bus.ready_i = 1'b1;
            end
        join
        wait_empty();
        repeat (2) tick();

        // 3: streaming, level pinned at 1, done high 16 consecutive cycles.
        bus.ready_i = 1'b1;
        d0 = done_total;
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            bus.valid_i = 1'b1;
            bus.state_i = rand128();
            tick();
            check("stream_level", 128'(bus.level_o), 128'(1));
        end
        bus.valid_i = 1'b0;
        repeat (4) tick();
        check("stream_done_count", 128'(done_total - d0), 128'(16));
        check("stream_done_run", 128'(max_run), 128'(16));

        // 4: asynchronous reset mid-operation.
        bus.ready_i = 1'b0;
        x = rand128(); y = rand128();
        send(x);
        send(y);
        check("rst_mid_level_before", 128'(bus.level_o), 128'(2));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 128'(bus.valid_o), 128'(0));
        check("rst_mid_level", 128'(bus.level_o), 128'(0));
        check("rst_mid_ready", 128'(bus.ready_o), 128'(1));
        check("rst_mid_state", bus.state_o, 128'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.ready_i = 1'b1;
        repeat (3) tick();
        check("rst_no_stale", 128'(bus.valid_o), 128'(0));

        // 5: round trip through forward ShiftRows with random downstream stalls.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    orig = rand128();
                    check("roundtrip_model", model_rot(model_rot(orig, 1'b0), 1'b1), orig);
                    send(model_rot(orig, 1'b0));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    bus.ready_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.ready_i = 1'b1;
        wait_empty();
        repeat (2) tick();
        check("final_err", 128'(bus.err_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
